// File: rtl/instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// instr_fetch_seq
// Read-side initiator for the instruction memory. Walks a program counter,
// reads 2-byte instructions (opcode, operand) and offers each one to the
// network controller over a valid/ready handshake. Fetching starts on a
// start pulse, stops on the halt opcode, and may be redirected by the
// controller with a jump at handshake time.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   start          single-cycle pulse; honoured only in IDLE or HALT
//   mem_address    address to instruction memory (Moore decoded)
//   mem_enable     memory read enable (Moore decoded)
//   mem_data       combinational read data, valid with address/enable
//   instr_opcode   latched opcode
//   instr_operand  latched operand
//   instr_pc       address of the current opcode byte
//   instr_valid    instruction available
//   instr_ready    consumer accepts the instruction
//   jump_en        redirect next fetch, sampled on handshake only
//   jump_addr      jump target, reduced modulo MEM_DEPTH
//   busy           high in FETCH_OP, FETCH_ARG and VALID
//   halted         high in HALT
// -----------------------------------------------------------------------------
// state     | meaning
// ----------|------------------------------------------------------------
// IDLE      | waiting for start, memory disabled
// FETCH_OP  | memory reads opcode at pc
// FETCH_ARG | memory reads operand at pc+1
// VALID     | instruction offered, waiting for instr_ready
// HALT      | halt opcode seen, waiting for start
// -----------------------------------------------------------------------------
module instr_fetch_seq #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    MEM_DEPTH   = 128,
  parameter int                    START_ADDR  = 0,
  parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_enable,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instr_opcode,
  output logic [DATA_WIDTH-1:0] instr_operand,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  busy,
  output logic                  halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    FETCH_ARG,
    VALID,
    HALT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(START_ADDR);
  localparam logic [31:0]           DEPTH_U  = 32'(MEM_DEPTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic [ADDR_WIDTH-1:0] pc_plus2;
  logic [ADDR_WIDTH-1:0] jump_pc;

  // One extra bit on the input keeps pc+1 / pc+2 from overflowing before
  // the modulo, so non-power-of-two depths wrap correctly too.
  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH:0] a);
    logic [31:0] ext;
    ext = 32'(a);
    return ADDR_WIDTH'(ext % DEPTH_U);
  endfunction

  assign pc_plus1 = wrap_addr({1'b0, pc} + (ADDR_WIDTH + 1)'(1));
  assign pc_plus2 = wrap_addr({1'b0, pc} + (ADDR_WIDTH + 1)'(2));
  assign jump_pc  = wrap_addr({1'b0, jump_addr});

  // Memory interface depends on state and pc only, so mem_data can never
  // feed back into the address it is read from.
  always_comb begin
    mem_enable  = 1'b0;
    mem_address = '0;
    case (state)
      FETCH_OP: begin
        mem_enable  = 1'b1;
        mem_address = pc;
      end
      FETCH_ARG: begin
        mem_enable  = 1'b1;
        mem_address = pc_plus1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= START_PC;
      instr_opcode  <= '0;
      instr_operand <= '0;
      instr_pc      <= '0;
      instr_valid   <= 1'b0;
      busy          <= 1'b0;
      halted        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH_OP;
            pc    <= START_PC;
            busy  <= 1'b1;
          end
        end

        FETCH_OP: begin
          instr_opcode <= mem_data;
          instr_pc     <= pc;
          if (mem_data == HALT_OPCODE) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= FETCH_ARG;
          end
        end

        FETCH_ARG: begin
          // Operand byte is plain data even if it equals the halt opcode.
          instr_operand <= mem_data;
          instr_valid   <= 1'b1;
          state         <= VALID;
        end

        VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH_OP;
            pc          <= jump_en ? jump_pc : pc_plus2;
          end
        end

        HALT: begin
          if (start) begin
            state  <= FETCH_OP;
            pc     <= START_PC;
            halted <= 1'b0;
            busy   <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
          busy        <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] mem_address;
  logic       mem_enable;
  wire  [7:0] mem_data;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic       busy;
  logic       halted;

  logic [7:0] mem [128];

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] arg;
    logic [7:0] pc;
  } instr_t;

  instr_t exp_q[$];
  int     halt_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  logic   prev_halted = 1'b0;
  int     lat;

  always #5 clk = ~clk;

  assign mem_data = mem_enable ? mem[mem_address[6:0]] : 8'bz;

  instr_fetch_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mem_address  (mem_address),
    .mem_enable   (mem_enable),
    .mem_data     (mem_data),
    .instr_opcode (instr_opcode),
    .instr_operand(instr_operand),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .busy         (busy),
    .halted       (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on each handshake and on each entry into HALT.
  always @(negedge clk) begin
    instr_t e;
    int     hp;
    if (!reset) begin
      if (instr_valid)
        chk("valid_opcode_not_halt", 32'(instr_opcode != 8'hFF), 32'd1);
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got op %0h pc %0h, required no instruction",
                   instr_opcode, instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_opcode", 32'(instr_opcode), 32'(e.op));
          chk("sb_operand", 32'(instr_operand), 32'(e.arg));
          chk("sb_pc", 32'(instr_pc), 32'(e.pc));
        end
      end
      if (halted && !prev_halted) begin
        if (halt_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected_halt: got pc %0h, required no halt", instr_pc);
        end else begin
          hp = halt_q.pop_front();
          chk("halt_opcode", 32'(instr_opcode), 32'hFF);
          chk("halt_pc", 32'(instr_pc), 32'(hp));
          chk("halt_valid_low", 32'(instr_valid), 32'd0);
        end
      end
    end
    prev_halted = halted;
  end

  task automatic push_i(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] pc);
    instr_t e;
    e.op  = op;
    e.arg = arg;
    e.pc  = pc;
    exp_q.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
  endtask

  task automatic load_prog1();
    clear_mem();
    mem[0] = 8'h02; mem[1] = 8'h10; mem[2] = 8'h03;
    mem[3] = 8'h20; mem[4] = 8'hFF; mem[5] = 8'h00;
  endtask

  task automatic do_reset();
    chk("queue_empty_instr", 32'(exp_q.size()), 32'd0);
    chk("queue_empty_halt", 32'(halt_q.size()), 32'd0);
    exp_q.delete();
    halt_q.delete();
    reset = 1'b1;
    start = 1'b0;
    jump_en = 1'b0;
    jump_addr = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Counts rising edges until instr_valid is seen; start, if requested, is
  // held for exactly the first edge.
  task automatic wait_valid(output int cycles, input bit do_start);
    if (do_start) start = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk);
      #1 start = 1'b0;
      cycles++;
    end while (!instr_valid && cycles < 20);
  endtask

  task automatic wait_halted();
    int n = 0;
    while (!halted && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
    chk("halt_busy_low", 32'(busy), 32'd0);
    chk("halt_mem_enable", 32'(mem_enable), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_opcode"}, 32'(instr_opcode), 32'd0);
    chk({tag, "_operand"}, 32'(instr_operand), 32'd0);
    chk({tag, "_pc"}, 32'(instr_pc), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_mem_enable"}, 32'(mem_enable), 32'd0);
    chk({tag, "_mem_address"}, 32'(mem_address), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    instr_ready = 1'b0;
    jump_en = 1'b0;
    jump_addr = 8'h00;
    clear_mem();

    // Reset state
    do_reset();
    chk_reset_outputs("reset");

    // 1: straight-line program with ready held high
    load_prog1();
    instr_ready = 1'b1;
    push_i(8'h02, 8'h10, 8'd0);
    push_i(8'h03, 8'h20, 8'd2);
    halt_q.push_back(4);
    wait_valid(lat, 1'b1);
    chk("t1_start_latency", 32'(lat), 32'd3);
    wait_halted();

    // 2: consumer stall
    do_reset();
    load_prog1();
    instr_ready = 1'b0;
    push_i(8'h02, 8'h10, 8'd0);
    push_i(8'h03, 8'h20, 8'd2);
    halt_q.push_back(4);
    wait_valid(lat, 1'b1);
    chk("t2_start_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t2_stall_valid", 32'(instr_valid), 32'd1);
      chk("t2_stall_opcode", 32'(instr_opcode), 32'h02);
      chk("t2_stall_operand", 32'(instr_operand), 32'h10);
      chk("t2_stall_pc", 32'(instr_pc), 32'd0);
      chk("t2_stall_mem_enable", 32'(mem_enable), 32'd0);
    end
    instr_ready = 1'b1;
    wait_valid(lat, 1'b0);
    chk("t2_handshake_latency", 32'(lat), 32'd3);
    wait_halted();

    // 3: jump to the last word, operand wraps to address 0
    do_reset();
    clear_mem();
    mem[0] = 8'h44; mem[1] = 8'hFF; mem[127] = 8'h05;
    instr_ready = 1'b0;
    push_i(8'h44, 8'hFF, 8'd0);
    push_i(8'h05, 8'h44, 8'd127);
    halt_q.push_back(1);
    wait_valid(lat, 1'b1);
    chk("t3_start_latency", 32'(lat), 32'd3);
    jump_en = 1'b1;
    jump_addr = 8'd127;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    jump_en = 1'b0;
    jump_addr = 8'd0;
    chk("t3_op_fetch_en", 32'(mem_enable), 32'd1);
    chk("t3_op_fetch_addr", 32'(mem_address), 32'd127);
    @(posedge clk);
    #1 chk("t3_arg_fetch_addr", 32'(mem_address), 32'd0);
    @(posedge clk);
    #1 chk("t3_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    @(posedge clk);
    #1 chk("t3_next_fetch_addr", 32'(mem_address), 32'd1);
    wait_halted();

    // 4: out-of-range jump target, jump without handshake ignored
    do_reset();
    clear_mem();
    mem[0] = 8'h02; mem[1] = 8'h10;
    mem[72] = 8'h07; mem[73] = 8'h77; mem[74] = 8'hFF;
    instr_ready = 1'b0;
    push_i(8'h02, 8'h10, 8'd0);
    push_i(8'h07, 8'h77, 8'd72);
    halt_q.push_back(74);
    wait_valid(lat, 1'b1);
    jump_en = 1'b1;
    jump_addr = 8'd5;
    @(posedge clk);
    #1 jump_en = 1'b0;
    chk("t4_nojump_valid", 32'(instr_valid), 32'd1);
    chk("t4_nojump_pc", 32'(instr_pc), 32'd0);
    chk("t4_nojump_mem_enable", 32'(mem_enable), 32'd0);
    jump_en = 1'b1;
    jump_addr = 8'd200;
    instr_ready = 1'b1;
    @(posedge clk);
    #1 jump_en = 1'b0;
    chk("t4_jump_fetch_en", 32'(mem_enable), 32'd1);
    chk("t4_jump_fetch_addr", 32'(mem_address), 32'd72);
    wait_halted();

    // 5: start during FETCH_ARG is ignored; start from HALT restarts
    do_reset();
    load_prog1();
    instr_ready = 1'b1;
    push_i(8'h02, 8'h10, 8'd0);
    push_i(8'h03, 8'h20, 8'd2);
    halt_q.push_back(4);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_in_fetch_arg_addr", 32'(mem_address), 32'd1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t5_valid_unchanged", 32'(instr_valid), 32'd1);
    chk("t5_busy", 32'(busy), 32'd1);
    wait_halted();
    push_i(8'h02, 8'h10, 8'd0);
    push_i(8'h03, 8'h20, 8'd2);
    halt_q.push_back(4);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t5_restart_halted_clear", 32'(halted), 32'd0);
    chk("t5_restart_busy", 32'(busy), 32'd1);
    chk("t5_restart_addr", 32'(mem_address), 32'd0);
    chk("t5_restart_en", 32'(mem_enable), 32'd1);
    wait_halted();

    // 6: reset in FETCH_ARG
    do_reset();
    load_prog1();
    instr_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("t6_reset");
    reset = 1'b0;
    push_i(8'h02, 8'h10, 8'd0);
    push_i(8'h03, 8'h20, 8'd2);
    halt_q.push_back(4);
    wait_valid(lat, 1'b1);
    chk("t6_start_latency", 32'(lat), 32'd3);
    wait_halted();

    chk("final_queue_instr", 32'(exp_q.size()), 32'd0);
    chk("final_queue_halt", 32'(halt_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Fetch sequencer: the read-side initiator for the 128x8 instruction memory. The memory read is combinational and gated by `enable`, with high-Z output when disabled.
- Walks a program counter and reads 2-byte instructions (opcode, operand), then presents each instruction to the network controller over a valid/ready handshake.
- Supports start, halt-opcode detection and controller-driven jumps.

Parameters:
- ADDR_WIDTH, 8, memory address width.
- DATA_WIDTH, 8, memory word / opcode / operand width.
- MEM_DEPTH, 128, number of valid memory words; the PC wraps modulo MEM_DEPTH.
- START_ADDR, 0, PC loaded on each start.
- HALT_OPCODE, 8'hFF, opcode that stops fetching.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins fetch at START_ADDR; honoured only in IDLE or HALT.
- mem_address  output  ADDR_WIDTH  address to instruction memory.
- mem_enable  output  1  memory read enable.
- mem_data  input  DATA_WIDTH  memory read data, valid in the same cycle as address/enable.
- instr_opcode  output  DATA_WIDTH  latched opcode.
- instr_operand  output  DATA_WIDTH  latched operand.
- instr_pc  output  ADDR_WIDTH  address of the current opcode byte.
- instr_valid  output  1  instruction available.
- instr_ready  input  1  consumer accepts the instruction.
- jump_en  input  1  sampled only on handshake; redirects the next fetch.
- jump_addr  input  ADDR_WIDTH  jump target; reduced modulo MEM_DEPTH.
- busy  output  1  high in FETCH_OP, FETCH_ARG and VALID.
- halted  output  1  high in HALT.

Behaviour:

States: IDLE, FETCH_OP, FETCH_ARG, VALID, HALT.

Reset:
- State goes to IDLE; pc = START_ADDR.
- instr_opcode, instr_operand, instr_pc, instr_valid, busy and halted are all 0.
- mem_enable = 0; mem_address = 0.

Memory outputs are Moore outputs, decoded from the state and PC registers only:
- FETCH_OP: mem_enable = 1, mem_address = pc.
- FETCH_ARG: mem_enable = 1, mem_address = (pc+1) mod MEM_DEPTH.
- All other states: mem_enable = 0, mem_address = 0.
- mem_data is sampled only at the rising edge that ends FETCH_OP or FETCH_ARG; at any other time it may be high-Z or X and must not propagate.

Transitions:
- IDLE:
  - start -> FETCH_OP, pc <= START_ADDR.
  - otherwise stay.
- FETCH_OP:
  - Latch instr_opcode <= mem_data and instr_pc <= pc.
  - If mem_data == HALT_OPCODE -> HALT.
  - Otherwise -> FETCH_ARG.
- FETCH_ARG:
  - Latch instr_operand <= mem_data.
  - -> VALID.
  - Set instr_valid <= 1.
- VALID:
  - Hold all instr_* outputs stable while instr_ready = 0.
  - On instr_ready = 1: instr_valid <= 0 and go to FETCH_OP.
    - If jump_en = 1: pc <= jump_addr mod MEM_DEPTH.
    - Otherwise: pc <= (pc+2) mod MEM_DEPTH.
- HALT:
  - halted = 1, instr_valid = 0.
  - instr_opcode holds HALT_OPCODE; instr_pc holds the halt address.
  - start -> FETCH_OP, pc <= START_ADDR, halted <= 0.

Latency and throughput:
- start edge to instr_valid high: 3 cycles (IDLE->FETCH_OP->FETCH_ARG->VALID).
- Handshake to next instr_valid: 3 cycles.
- Maximum rate is one instruction per 3 cycles.

Boundary conditions:
- Opcode at MEM_DEPTH-1: the operand is read from address 0.
- PC increment wraps modulo MEM_DEPTH.
- jump_addr >= MEM_DEPTH is reduced modulo MEM_DEPTH.
- start while busy is ignored; jump_en outside a handshake is ignored.
- instr_ready while instr_valid = 0 has no effect.
- HALT_OPCODE appearing in the operand position is data, not a halt.
- Reset asserted in any state overrides all other inputs; the next cycle is IDLE with all reset values.

Test Plan:
1. mem[0..5] = 02,10,03,20,FF,00; pulse start with instr_ready = 1.
   -> instr_valid first seen high 3 cycles after start with opcode 02, operand 10, pc 0.
   -> then 03/20/pc 2.
   -> then halted = 1 with instr_opcode FF, instr_pc 4; instr_valid never asserted for FF.
2. Same program, instr_ready held 0 for 5 cycles after the first valid.
   -> instr_valid stays high; 02/10/pc 0 stay stable; mem_enable = 0 during the stall.
   -> the second instruction appears 3 cycles after ready rises.
3. mem[127] = 05, mem[0] = 44; jump to 127 on the first handshake.
   -> opcode 05, operand 44, instr_pc 127.
   -> next fetch address is 1.
4. jump_en = 1 with jump_addr = 200 on a handshake.
   -> next fetch at 72 (200 mod 128).
   -> jump_en pulsed while instr_ready = 0 has no effect.
5. start pulsed in FETCH_ARG -> ignored, sequence unchanged.
   - From HALT, start -> refetch from address 0 and halted clears.
6. Assert reset during FETCH_ARG.
   -> next cycle: IDLE, all outputs 0, mem_enable 0.
   -> a subsequent start yields pc 0.
